// File: rtl/mp_add_pkg.sv
// Shared types and helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_state_t;

    // Width of the slice index counter; never narrower than one bit so a
    // single-slice configuration still has a legal counter.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/pa.sv
// One N-bit ripple slice: y/c_out = a + b + c_in.
module pa #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] y,
    output logic         c_out
);

    assign {c_out, y} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: walks one N-bit slice over WORDS
// cycles, chaining the carry through a register.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; ready=1, slice inputs held at zero
// RUN   | slice idx active; one word of result written per clock
// DONE  | result, c_out and overflow valid; done pulses for one cycle
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter  int N     = 8,
    parameter  int WORDS = 4,
    localparam int W     = N * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] result,
    output logic         c_out,
    output logic         overflow
);

    localparam int IW = idx_width(WORDS);
    localparam logic [W-1:0] SLICE_MASK = W'({N{1'b1}});

    mp_state_t state_q, state_d;

    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_eff_q;
    logic [W-1:0]  result_q;
    logic          c_out_q;
    logic          ovf_q;

    logic [N-1:0]  slice_a;
    logic [N-1:0]  slice_b;
    logic          slice_cin;
    logic [N-1:0]  slice_y;
    logic          slice_cout;

    logic [31:0]   bit_ofs;
    logic          last_word;
    logic          accept;

    assign bit_ofs   = 32'(idx_q) * 32'(N);
    assign last_word = (idx_q == IW'(WORDS - 1));
    assign accept    = (state_q == IDLE) && start;

    pa #(.N(N)) pa_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (slice_cin),
        .y     (slice_y),
        .c_out (slice_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and slice drive; slice inputs are zero outside RUN.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        done      = 1'b0;
        slice_a   = '0;
        slice_b   = '0;
        slice_cin = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                slice_a   = N'(a_q >> bit_ofs);
                slice_b   = N'(b_eff_q >> bit_ofs);
                slice_cin = carry_q;
                if (last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch on accept, then one result word and carry per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_eff_q  <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1: invert B once here and seed the carry.
            a_q      <= a;
            b_eff_q  <= sub ? ~b : b;
            carry_q  <= sub;
            idx_q    <= '0;
            result_q <= '0;
        end else if (state_q == RUN) begin
            result_q <= (result_q & ~(SLICE_MASK << bit_ofs))
                      | (W'(slice_y) << bit_ofs);
            carry_q  <= slice_cout;
            idx_q    <= idx_q + IW'(1);
            if (last_word) begin
                c_out_q <= slice_cout;
                ovf_q   <= (a_q[W-1] == b_eff_q[W-1]) && (slice_y[N-1] != a_q[W-1]);
            end
        end
    end

    assign result   = result_q;
    assign c_out    = c_out_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed and random checks of mp_add_seq at N=8/WORDS=4 and N=16/WORDS=1.
module tb_mp_add_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, sub = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        ready, done, c_out, overflow;
    logic [31:0] result;

    logic        start2 = 1'b0, sub2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;
    logic        ready2, done2, c_out2, overflow2;
    logic [15:0] result2;

    int total = 0;
    int bad   = 0;

    mp_add_seq #(.N(8), .WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .c_out(c_out), .overflow(overflow)
    );

    mp_add_seq #(.N(16), .WORDS(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .ready(ready2), .done(done2), .result(result2), .c_out(c_out2), .overflow(overflow2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {overflow, c_out, result} for the 32-bit configuration
    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [31:0] be;
        logic [32:0] sum;
        be  = s ? ~y : y;
        sum = {1'b0, x} + {1'b0, be} + 33'(s);
        return {(x[31] == be[31]) && (sum[31] != x[31]), sum};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic s);
        logic [15:0] be;
        logic [16:0] sum;
        be  = s ? ~y : y;
        sum = {1'b0, x} + {1'b0, be} + 17'(s);
        return {(x[15] == be[15]) && (sum[15] != x[15]), sum};
    endfunction

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic vs);
        chk("launch_ready", ready, 1'b1);
        a = va; b = vb; sub = vs; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges since the accepting edge until done, recording slice c_in.
    task automatic finish(input int k0, output logic [31:0] r, output logic c, output logic ov,
                          output int lat, output logic [3:0] cins);
        int k;
        k = k0; lat = -1; cins = '0;
        while (k <= 20) begin
            if (done === 1'b1) begin
                lat = k;
                break;
            end
            if (k >= 1 && k <= 4) cins[k-1] = dut.pa_slice.c_in;
            @(negedge clk);
            k++;
        end
        r = result; c = c_out; ov = overflow;
    endtask

    task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vs,
                          output logic [31:0] r, output logic c, output logic ov,
                          output logic [3:0] cins);
        int lat;
        launch(va, vb, vs);
        finish(1, r, c, ov, lat, cins);
        chk("latency", lat, 5);
        @(negedge clk);
        chk("done_single_pulse", done, 1'b0);
        chk("ready_after_done", ready, 1'b1);
        chk("result_held", result, r);
    endtask

    task automatic run_op2(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                           output logic [15:0] r, output logic c, output logic ov);
        int k;
        int lat;
        chk("launch2_ready", ready2, 1'b1);
        a2 = va; b2 = vb; sub2 = vs; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        k = 1; lat = -1;
        while (k <= 10) begin
            if (done2 === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clk);
            k++;
        end
        r = result2; c = c_out2; ov = overflow2;
        chk("latency2", lat, 2);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] r;
        logic        c, ov;
        logic [3:0]  cins;
        logic [15:0] r16;
        logic [33:0] m32;
        logic [17:0] m16;
        logic [31:0] va, vb;
        logic        vs;
        int          lat;

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_ready", ready, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'h0);
        chk("rst_c_out", c_out, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_ready2", ready2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Full carry ripple
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, r, c, ov, cins);
        chk("ripple_result", r, 32'h0);
        chk("ripple_c_out", c, 1'b1);
        chk("ripple_ovf", ov, 1'b0);
        chk("ripple_c_in_seq", cins, 4'b1110);

        // Subtract with borrow, then without
        run_op(32'h0, 32'h1, 1'b1, r, c, ov, cins);
        chk("borrow_result", r, 32'hFFFF_FFFF);
        chk("borrow_c_out", c, 1'b0);
        chk("borrow_ovf", ov, 1'b0);
        run_op(32'd5, 32'd3, 1'b1, r, c, ov, cins);
        chk("sub5_3_result", r, 32'd2);
        chk("sub5_3_c_out", c, 1'b1);

        // Signed overflow, both directions
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, r, c, ov, cins);
        chk("posovf_result", r, 32'h8000_0000);
        chk("posovf_ovf", ov, 1'b1);
        chk("posovf_c_out", c, 1'b0);
        run_op(32'h8000_0000, 32'h1, 1'b1, r, c, ov, cins);
        chk("negovf_result", r, 32'h7FFF_FFFF);
        chk("negovf_ovf", ov, 1'b1);
        chk("negovf_c_out", c, 1'b1);

        // Start pulsed during RUN is ignored and not queued
        launch(32'h1234_5678, 32'h1111_1111, 1'b0);
        a = 32'h1; b = 32'h2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish(2, r, c, ov, lat, cins);
        chk("busy_latency", lat, 5);
        chk("busy_result", r, 32'h2345_6789);
        chk("busy_c_out", c, 1'b0);
        @(negedge clk);
        chk("busy_ready", ready, 1'b1);
        @(negedge clk);
        chk("busy_not_queued", ready, 1'b1);
        chk("busy_result_held", result, 32'h2345_6789);

        // Back-to-back: the second op launches in the first ready cycle
        run_op(32'h0000_0003, 32'h0000_0005, 1'b1, r, c, ov, cins);
        chk("b2b1_result", r, 32'hFFFF_FFFE);
        chk("b2b1_c_out", c, 1'b0);
        run_op(32'hAAAA_AAAA, 32'h5555_5555, 1'b0, r, c, ov, cins);
        chk("b2b2_result", r, 32'hFFFF_FFFF);
        chk("b2b2_c_out", c, 1'b0);

        // Asynchronous reset at idx=2
        launch(32'h0101_0101, 32'h0202_0202, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_partial", result, 32'h0000_0303);
        #1 rst = 1'b1;
        #1;
        chk("midrst_result", result, 32'h0);
        chk("midrst_ready", ready, 1'b1);
        chk("midrst_done", done, 1'b0);
        chk("midrst_c_out", c_out, 1'b0);
        chk("midrst_ovf", overflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(32'd10, 32'd20, 1'b0, r, c, ov, cins);
        chk("postrst_result", r, 32'd30);
        chk("postrst_c_out", c, 1'b0);
        chk("postrst_ovf", ov, 1'b0);

        // Random sweep, 32-bit
        for (int i = 0; i < 1000; i++) begin
            va = $urandom;
            vb = $urandom;
            vs = 1'($urandom_range(0, 1));
            if (i % 50 == 0) vb = va;
            m32 = model32(va, vb, vs);
            run_op(va, vb, vs, r, c, ov, cins);
            chk("sweep_result", r, m32[31:0]);
            chk("sweep_c_out", c, m32[32]);
            chk("sweep_ovf", ov, m32[33]);
        end

        // Single-slice configuration
        run_op2(16'h7FFF, 16'h0001, 1'b0, r16, c, ov);
        chk("w1_posovf_result", r16, 16'h8000);
        chk("w1_posovf_ovf", ov, 1'b1);
        run_op2(16'h0000, 16'h0001, 1'b1, r16, c, ov);
        chk("w1_borrow_result", r16, 16'hFFFF);
        chk("w1_borrow_c_out", c, 1'b0);
        for (int i = 0; i < 300; i++) begin
            va = $urandom;
            vb = $urandom;
            vs = 1'($urandom_range(0, 1));
            m16 = model16(va[15:0], vb[15:0], vs);
            run_op2(va[15:0], vb[15:0], vs, r16, c, ov);
            chk("w1_sweep_result", r16, m16[15:0]);
            chk("w1_sweep_c_out", c, m16[16]);
            chk("w1_sweep_ovf", ov, m16[17]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
